// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: op codes, ROB tag width, entry
// and ALU-dispatch records, and the CDB tag-match helper.
package reservation_station_pkg;

   localparam int unsigned ENTRY_W = 4;
   localparam int unsigned OP_W    = 6;

   typedef enum logic [OP_W-1:0] {
      OP_NOP  = 6'd0,
      OP_ADD  = 6'd1,
      OP_SUB  = 6'd2,
      OP_AND  = 6'd3,
      OP_OR   = 6'd4,
      OP_XOR  = 6'd5,
      OP_SLL  = 6'd6,
      OP_SRL  = 6'd7,
      OP_SRA  = 6'd8,
      OP_SLT  = 6'd9,
      OP_SLTU = 6'd10,
      OP_BEQ  = 6'd11,
      OP_BNE  = 6'd12,
      OP_JAL  = 6'd13,
      OP_JALR = 6'd14
   } op_e;

   typedef struct packed {
      logic               busy;
      logic [OP_W-1:0]    op;
      logic [31:0]        instruction;
      logic [31:0]        pc;
      logic [31:0]        imm;
      logic [31:0]        vj;
      logic [31:0]        vk;
      logic [ENTRY_W-1:0] qj;
      logic [ENTRY_W-1:0] qk;
      logic               rj;
      logic               rk;
      logic [ENTRY_W-1:0] entry;
   } rs_entry_t;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [31:0]        instruction;
      logic [31:0]        vj;
      logic [31:0]        vk;
      logic [31:0]        pc;
      logic [31:0]        imm;
      logic [ENTRY_W-1:0] entry;
   } alu_out_t;

   function automatic logic cdb_hit(input logic               valid,
                                    input logic [ENTRY_W-1:0] bus_tag,
                                    input logic [ENTRY_W-1:0] q);
      return valid && (bus_tag == q);
   endfunction

endpackage

// File: rtl/reservation_station_priority_select.sv
// Lowest-index priority picker over a request vector.
module rs_priority_select #(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic [N-1:0]     req_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req_i[i] && !found_o) begin
            found_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers issued ALU/branch ops, wakes operands from the
// ALU and LSB result buses, and dispatches one ready entry per cycle.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int unsigned RS_SIZE  = 16,
   parameter int unsigned RS_IDX_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               clear,
   input  logic               issue_valid,
   input  logic [5:0]         issue_op,
   input  logic [31:0]        issue_instruction,
   input  logic [31:0]        issue_pc,
   input  logic [31:0]        issue_imm,
   input  logic               issue_rj,
   input  logic               issue_rk,
   input  logic [31:0]        issue_vj,
   input  logic [31:0]        issue_vk,
   input  logic [ENTRY_W-1:0] issue_qj,
   input  logic [ENTRY_W-1:0] issue_qk,
   input  logic [ENTRY_W-1:0] issue_entry,
   output logic               rs_full,
   output logic               alu_new_calculate,
   output logic [5:0]         alu_op,
   output logic [31:0]        alu_instruction,
   output logic [31:0]        alu_vj,
   output logic [31:0]        alu_vk,
   output logic [31:0]        alu_pc,
   output logic [31:0]        alu_imm,
   output logic [ENTRY_W-1:0] alu_entry,
   input  logic               cdb_alu_valid,
   input  logic [31:0]        cdb_alu_result,
   input  logic [ENTRY_W-1:0] cdb_alu_entry,
   input  logic               cdb_lsb_valid,
   input  logic [31:0]        cdb_lsb_result,
   input  logic [ENTRY_W-1:0] cdb_lsb_entry
);

   rs_entry_t ent_q [RS_SIZE];
   rs_entry_t ent_d [RS_SIZE];
   alu_out_t  alu_q, alu_d;
   logic      stb_q, stb_d;

   logic [RS_SIZE-1:0]  busy_vec, ready_vec;
   logic                free_found, ready_found;
   logic [RS_IDX_W-1:0] free_idx, ready_idx;
   rs_entry_t           new_ent;

   always_comb begin
      busy_vec  = '0;
      ready_vec = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         busy_vec[i]  = ent_q[i].busy;
         ready_vec[i] = ent_q[i].busy && ent_q[i].rj && ent_q[i].rk;
      end
   end

   assign rs_full = &busy_vec;

   rs_priority_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
      .req_i   (~busy_vec),
      .found_o (free_found),
      .idx_o   (free_idx)
   );

   rs_priority_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
      .req_i   (ready_vec),
      .found_o (ready_found),
      .idx_o   (ready_idx)
   );

   // Incoming instruction with same-cycle CDB bypass; ALU bus wins over LSB bus.
   always_comb begin
      new_ent = '{busy: 1'b1, op: issue_op, instruction: issue_instruction,
                  pc: issue_pc, imm: issue_imm, vj: issue_vj, vk: issue_vk,
                  qj: issue_qj, qk: issue_qk, rj: issue_rj, rk: issue_rk,
                  entry: issue_entry};
      if (!issue_rj) begin
         if (cdb_hit(cdb_alu_valid, cdb_alu_entry, issue_qj)) begin
            new_ent.vj = cdb_alu_result;
            new_ent.rj = 1'b1;
         end else if (cdb_hit(cdb_lsb_valid, cdb_lsb_entry, issue_qj)) begin
            new_ent.vj = cdb_lsb_result;
            new_ent.rj = 1'b1;
         end
      end
      if (!issue_rk) begin
         if (cdb_hit(cdb_alu_valid, cdb_alu_entry, issue_qk)) begin
            new_ent.vk = cdb_alu_result;
            new_ent.rk = 1'b1;
         end else if (cdb_hit(cdb_lsb_valid, cdb_lsb_entry, issue_qk)) begin
            new_ent.vk = cdb_lsb_result;
            new_ent.rk = 1'b1;
         end
      end
   end

   always_comb begin
      ent_d = ent_q;
      alu_d = alu_q;
      stb_d = 1'b0;
      if (clear) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
      end else if (rdy) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy && !ent_q[i].rj) begin
               if (cdb_hit(cdb_alu_valid, cdb_alu_entry, ent_q[i].qj)) begin
                  ent_d[i].vj = cdb_alu_result;
                  ent_d[i].rj = 1'b1;
               end else if (cdb_hit(cdb_lsb_valid, cdb_lsb_entry, ent_q[i].qj)) begin
                  ent_d[i].vj = cdb_lsb_result;
                  ent_d[i].rj = 1'b1;
               end
            end
            if (ent_q[i].busy && !ent_q[i].rk) begin
               if (cdb_hit(cdb_alu_valid, cdb_alu_entry, ent_q[i].qk)) begin
                  ent_d[i].vk = cdb_alu_result;
                  ent_d[i].rk = 1'b1;
               end else if (cdb_hit(cdb_lsb_valid, cdb_lsb_entry, ent_q[i].qk)) begin
                  ent_d[i].vk = cdb_lsb_result;
                  ent_d[i].rk = 1'b1;
               end
            end
         end
         if (ready_found) begin
            ent_d[ready_idx].busy = 1'b0;
            alu_d = '{op: ent_q[ready_idx].op, instruction: ent_q[ready_idx].instruction,
                      vj: ent_q[ready_idx].vj, vk: ent_q[ready_idx].vk,
                      pc: ent_q[ready_idx].pc, imm: ent_q[ready_idx].imm,
                      entry: ent_q[ready_idx].entry};
            stb_d = 1'b1;
         end
         // free_idx comes from start-of-cycle busy, so a slot freed by this dispatch is not reused
         if (issue_valid && !rs_full && free_found) ent_d[free_idx] = new_ent;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
         alu_q <= '0;
         stb_q <= 1'b0;
      end else begin
         ent_q <= ent_d;
         alu_q <= alu_d;
         stb_q <= stb_d;
      end
   end

   assign alu_new_calculate = stb_q;
   assign alu_op            = alu_q.op;
   assign alu_instruction   = alu_q.instruction;
   assign alu_vj            = alu_q.vj;
   assign alu_vk            = alu_q.vk;
   assign alu_pc            = alu_q.pc;
   assign alu_imm           = alu_q.imm;
   assign alu_entry         = alu_q.entry;

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus a
// randomized run against a behavioural model of the station.
module tb_reservation_station;
   import reservation_station_pkg::*;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1, rdy = 1'b1, clear = 1'b0;
   logic        issue_valid = 1'b0;
   logic [5:0]  issue_op = '0;
   logic [31:0] issue_instruction = '0, issue_pc = '0, issue_imm = '0;
   logic        issue_rj = 1'b0, issue_rk = 1'b0;
   logic [31:0] issue_vj = '0, issue_vk = '0;
   logic [3:0]  issue_qj = '0, issue_qk = '0, issue_entry = '0;
   logic        rs_full, alu_new_calculate;
   logic [5:0]  alu_op;
   logic [31:0] alu_instruction, alu_vj, alu_vk, alu_pc, alu_imm;
   logic [3:0]  alu_entry;
   logic        cdb_alu_valid = 1'b0, cdb_lsb_valid = 1'b0;
   logic [31:0] cdb_alu_result = '0, cdb_lsb_result = '0;
   logic [3:0]  cdb_alu_entry = '0, cdb_lsb_entry = '0;

   int checks = 0;
   int failures = 0;

   reservation_station #(.RS_SIZE(16), .RS_IDX_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_instruction(issue_instruction), .issue_pc(issue_pc), .issue_imm(issue_imm),
      .issue_rj(issue_rj), .issue_rk(issue_rk), .issue_vj(issue_vj), .issue_vk(issue_vk),
      .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_entry(issue_entry),
      .rs_full(rs_full), .alu_new_calculate(alu_new_calculate), .alu_op(alu_op),
      .alu_instruction(alu_instruction), .alu_vj(alu_vj), .alu_vk(alu_vk),
      .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_entry(alu_entry),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_result(cdb_alu_result), .cdb_alu_entry(cdb_alu_entry),
      .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_result(cdb_lsb_result), .cdb_lsb_entry(cdb_lsb_entry)
   );

   always #5 clk = ~clk;

   // Dispatcher must never present an instruction to a full station.
   always @(posedge clk) begin
      if (!rst && rdy && !clear)
         assert (!(issue_valid && rs_full)) else $error("issue_valid while rs_full");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid   = 1'b0;
      cdb_alu_valid = 1'b0;
      cdb_lsb_valid = 1'b0;
      clear         = 1'b0;
   endtask

   task automatic set_issue(input logic [5:0] op, input logic rj, input logic [31:0] vj,
                            input logic [3:0] qj, input logic rk, input logic [31:0] vk,
                            input logic [3:0] qk, input logic [3:0] ent, input logic [31:0] pc);
      issue_valid = 1'b1; issue_op = op; issue_rj = rj; issue_vj = vj; issue_qj = qj;
      issue_rk = rk; issue_vk = vk; issue_qk = qk; issue_entry = ent; issue_pc = pc;
      issue_imm = pc ^ 32'h5A5A_0000; issue_instruction = {pc[15:0], 16'h0013};
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); rdy = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (rs_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rs_full); end
      checks++;
      if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", alu_new_calculate); end
      checks++;
      if ({alu_op, alu_instruction, alu_vj, alu_vk, alu_pc, alu_imm, alu_entry} !== '0) begin
         failures++; $display("FAIL reset_alu_data got op=%h vj=%h vk=%h pc=%h entry=%h exp all zero",
                              alu_op, alu_vj, alu_vk, alu_pc, alu_entry);
      end
   endtask

   task automatic test_ready_issue();
      set_issue(OP_ADD, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3, 32'h100);
      tick(); idle();
      checks++;
      if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL ready_early_strobe got=%b exp=0", alu_new_calculate); end
      tick();
      checks++;
      if (alu_new_calculate !== 1'b1 || alu_op !== OP_ADD || alu_vj !== 32'd5 || alu_vk !== 32'd7
          || alu_entry !== 4'd3 || alu_pc !== 32'h100) begin
         failures++; $display("FAIL ready_dispatch got stb=%b op=%0d vj=%0d vk=%0d entry=%0d pc=%h exp stb=1 op=1 vj=5 vk=7 entry=3 pc=100",
                              alu_new_calculate, alu_op, alu_vj, alu_vk, alu_entry, alu_pc);
      end
      tick();
      checks++;
      if (alu_new_calculate !== 1'b0 || alu_vj !== 32'd5) begin
         failures++; $display("FAIL ready_one_cycle got stb=%b vj=%0d exp stb=0 vj=5", alu_new_calculate, alu_vj);
      end
   endtask

   task automatic test_wakeup();
      set_issue(OP_SUB, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd5, 32'h200);
      tick(); idle();
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL wake_premature c=%0d got=%b exp=0", c, alu_new_calculate); end
      end
      cdb_alu_valid = 1'b1; cdb_alu_entry = 4'd2; cdb_alu_result = 32'd10;
      tick(); idle();
      checks++;
      if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL wake_capture_cycle got=%b exp=0", alu_new_calculate); end
      tick();
      checks++;
      if (alu_new_calculate !== 1'b1 || alu_op !== OP_SUB || alu_vj !== 32'd10 || alu_vk !== 32'd1 || alu_entry !== 4'd5) begin
         failures++; $display("FAIL wake_dispatch got stb=%b op=%0d vj=%0d vk=%0d entry=%0d exp stb=1 op=2 vj=10 vk=1 entry=5",
                              alu_new_calculate, alu_op, alu_vj, alu_vk, alu_entry);
      end
      tick();
   endtask

   task automatic test_issue_bypass();
      set_issue(OP_XOR, 1'b1, 32'd3, 4'd0, 1'b0, 32'd0, 4'd4, 4'd6, 32'h300);
      cdb_lsb_valid = 1'b1; cdb_lsb_entry = 4'd4; cdb_lsb_result = 32'hDEADBEEF;
      tick(); idle();
      tick();
      checks++;
      if (alu_new_calculate !== 1'b1 || alu_vk !== 32'hDEADBEEF || alu_vj !== 32'd3 || alu_entry !== 4'd6) begin
         failures++; $display("FAIL bypass_dispatch got stb=%b vj=%h vk=%h entry=%0d exp stb=1 vj=3 vk=deadbeef entry=6",
                              alu_new_calculate, alu_vj, alu_vk, alu_entry);
      end
      tick();
   endtask

   task automatic test_fill_full();
      for (int i = 0; i < N; i++) begin
         set_issue(OP_AND, 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0, 4'(i), 32'(i * 4));
         tick();
      end
      idle();
      checks++;
      if (rs_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", rs_full); end
      cdb_alu_valid = 1'b1; cdb_alu_entry = 4'd9; cdb_alu_result = 32'h99;
      tick(); idle();
      checks++;
      if (alu_new_calculate !== 1'b0 || rs_full !== 1'b1) begin
         failures++; $display("FAIL fill_wake_cycle got stb=%b full=%b exp stb=0 full=1", alu_new_calculate, rs_full);
      end
      for (int i = 0; i < N; i++) begin
         tick();
         checks++;
         if (alu_new_calculate !== 1'b1 || alu_entry !== 4'(i) || alu_vj !== 32'h99
             || alu_vk !== 32'(i) || alu_pc !== 32'(i * 4) || rs_full !== 1'b0) begin
            failures++; $display("FAIL fill_drain i=%0d got stb=%b entry=%0d vj=%h vk=%0d full=%b exp stb=1 entry=%0d vj=99 vk=%0d full=0",
                                 i, alu_new_calculate, alu_entry, alu_vj, alu_vk, rs_full, i, i);
         end
      end
      tick();
      checks++;
      if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL fill_after_drain got=%b exp=0", alu_new_calculate); end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) begin
         set_issue(OP_OR, 1'b0, 32'd0, 4'd7, 1'b1, 32'd1, 4'd0, 4'(10 + i), 32'h400);
         tick();
      end
      idle();
      cdb_alu_valid = 1'b1; cdb_alu_entry = 4'd7; cdb_alu_result = 32'h77;
      tick(); idle();
      clear = 1'b1;
      set_issue(OP_ADD, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd15, 32'h500);
      tick(); idle();
      checks++;
      if (alu_new_calculate !== 1'b0 || rs_full !== 1'b0) begin
         failures++; $display("FAIL clear_edge got stb=%b full=%b exp stb=0 full=0", alu_new_calculate, rs_full);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL clear_residue c=%0d got stb=%b entry=%0d exp stb=0", c, alu_new_calculate, alu_entry); end
      end
   endtask

   task automatic test_rdy_freeze();
      set_issue(OP_SLT, 1'b0, 32'd0, 4'd6, 1'b1, 32'd2, 4'd0, 4'd1, 32'h600);
      tick();
      set_issue(OP_SLTU, 1'b1, 32'h11, 4'd0, 1'b1, 32'h22, 4'd0, 4'd2, 32'h700);
      tick(); idle();
      rdy = 1'b0;
      cdb_alu_valid = 1'b1; cdb_alu_entry = 4'd6; cdb_alu_result = 32'h66;
      for (int c = 0; c < 3; c++) begin
         tick();
         cdb_alu_valid = 1'b0;
         checks++;
         if (alu_new_calculate !== 1'b0 || alu_vj !== 32'h99) begin
            failures++; $display("FAIL freeze c=%0d got stb=%b vj=%h exp stb=0 vj=99", c, alu_new_calculate, alu_vj);
         end
      end
      rdy = 1'b1;
      tick();
      checks++;
      if (alu_new_calculate !== 1'b1 || alu_entry !== 4'd2 || alu_vj !== 32'h11 || alu_vk !== 32'h22) begin
         failures++; $display("FAIL resume_dispatch got stb=%b entry=%0d vj=%h vk=%h exp stb=1 entry=2 vj=11 vk=22",
                              alu_new_calculate, alu_entry, alu_vj, alu_vk);
      end
      tick();
      checks++;
      if (alu_new_calculate !== 1'b0) begin failures++; $display("FAIL freeze_no_capture got stb=%b entry=%0d exp stb=0", alu_new_calculate, alu_entry); end
      cdb_lsb_valid = 1'b1; cdb_lsb_entry = 4'd6; cdb_lsb_result = 32'h88;
      tick(); idle();
      tick();
      checks++;
      if (alu_new_calculate !== 1'b1 || alu_entry !== 4'd1 || alu_vj !== 32'h88 || alu_vk !== 32'd2) begin
         failures++; $display("FAIL freeze_late_wake got stb=%b entry=%0d vj=%h vk=%h exp stb=1 entry=1 vj=88 vk=2",
                              alu_new_calculate, alu_entry, alu_vj, alu_vk);
      end
      tick();
   endtask

   // Behavioural model: a table of pending instructions plus the last dispatch.
   bit          m_busy [N], m_rj [N], m_rk [N];
   logic [5:0]  m_op [N];
   logic [31:0] m_ins [N], m_pc [N], m_imm [N], m_vj [N], m_vk [N];
   logic [3:0]  m_qj [N], m_qk [N], m_ent [N];
   bit          e_stb;
   logic [5:0]  e_op;
   logic [31:0] e_ins, e_vj, e_vk, e_pc, e_imm;
   logic [3:0]  e_ent;

   function automatic bit model_full();
      for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      int disp = -1;
      int slot = -1;
      e_stb = 1'b0;
      if (clear) begin
         for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
         return;
      end
      if (!rdy) return;
      for (int i = 0; i < N; i++) begin
         if (disp < 0 && m_busy[i] && m_rj[i] && m_rk[i]) disp = i;
         if (slot < 0 && !m_busy[i]) slot = i;
      end
      for (int i = 0; i < N; i++) begin
         if (!m_busy[i]) continue;
         if (!m_rj[i] && cdb_alu_valid && cdb_alu_entry == m_qj[i]) begin m_vj[i] = cdb_alu_result; m_rj[i] = 1'b1; end
         else if (!m_rj[i] && cdb_lsb_valid && cdb_lsb_entry == m_qj[i]) begin m_vj[i] = cdb_lsb_result; m_rj[i] = 1'b1; end
         if (!m_rk[i] && cdb_alu_valid && cdb_alu_entry == m_qk[i]) begin m_vk[i] = cdb_alu_result; m_rk[i] = 1'b1; end
         else if (!m_rk[i] && cdb_lsb_valid && cdb_lsb_entry == m_qk[i]) begin m_vk[i] = cdb_lsb_result; m_rk[i] = 1'b1; end
      end
      if (disp >= 0) begin
         e_stb = 1'b1; m_busy[disp] = 1'b0;
         e_op = m_op[disp]; e_ins = m_ins[disp]; e_vj = m_vj[disp]; e_vk = m_vk[disp];
         e_pc = m_pc[disp]; e_imm = m_imm[disp]; e_ent = m_ent[disp];
      end
      if (issue_valid && slot >= 0) begin
         m_busy[slot] = 1'b1; m_op[slot] = issue_op; m_ins[slot] = issue_instruction;
         m_pc[slot] = issue_pc; m_imm[slot] = issue_imm; m_ent[slot] = issue_entry;
         m_rj[slot] = issue_rj; m_vj[slot] = issue_vj; m_qj[slot] = issue_qj;
         m_rk[slot] = issue_rk; m_vk[slot] = issue_vk; m_qk[slot] = issue_qk;
         if (!issue_rj && cdb_alu_valid && cdb_alu_entry == issue_qj) begin m_vj[slot] = cdb_alu_result; m_rj[slot] = 1'b1; end
         else if (!issue_rj && cdb_lsb_valid && cdb_lsb_entry == issue_qj) begin m_vj[slot] = cdb_lsb_result; m_rj[slot] = 1'b1; end
         if (!issue_rk && cdb_alu_valid && cdb_alu_entry == issue_qk) begin m_vk[slot] = cdb_alu_result; m_rk[slot] = 1'b1; end
         else if (!issue_rk && cdb_lsb_valid && cdb_lsb_entry == issue_qk) begin m_vk[slot] = cdb_lsb_result; m_rk[slot] = 1'b1; end
      end
   endtask

   task automatic test_random();
      rst = 1'b1; idle(); rdy = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      e_stb = 1'b0; e_op = '0; e_ins = '0; e_vj = '0; e_vk = '0; e_pc = '0; e_imm = '0; e_ent = '0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         rdy   = ($urandom_range(0, 7) != 0);
         clear = ($urandom_range(0, 49) == 0);
         issue_valid = !model_full() && ($urandom_range(0, 2) != 0);
         issue_op = 6'($urandom_range(1, 14));
         issue_instruction = $urandom(); issue_pc = $urandom(); issue_imm = $urandom();
         issue_rj = $urandom_range(0, 1) != 0; issue_vj = $urandom(); issue_qj = 4'($urandom_range(0, 15));
         issue_rk = $urandom_range(0, 1) != 0; issue_vk = $urandom(); issue_qk = 4'($urandom_range(0, 15));
         issue_entry = 4'($urandom_range(0, 15));
         cdb_alu_valid = ($urandom_range(0, 1) != 0); cdb_alu_entry = 4'($urandom_range(0, 15)); cdb_alu_result = $urandom();
         cdb_lsb_valid = ($urandom_range(0, 2) == 0); cdb_lsb_entry = 4'($urandom_range(0, 15)); cdb_lsb_result = $urandom();
         if (cdb_lsb_entry == cdb_alu_entry) cdb_lsb_valid = 1'b0;
         model_edge();
         tick();
         checks++;
         if (alu_new_calculate !== e_stb) begin
            failures++; $display("FAIL rand_strobe cyc=%0d got=%b exp=%b", cyc, alu_new_calculate, e_stb);
         end
         checks++;
         if ({alu_op, alu_instruction, alu_vj, alu_vk, alu_pc, alu_imm, alu_entry} !==
             {e_op, e_ins, e_vj, e_vk, e_pc, e_imm, e_ent}) begin
            failures++; $display("FAIL rand_alu_data cyc=%0d got op=%0d vj=%h vk=%h pc=%h entry=%0d exp op=%0d vj=%h vk=%h pc=%h entry=%0d",
                                 cyc, alu_op, alu_vj, alu_vk, alu_pc, alu_entry, e_op, e_vj, e_vk, e_pc, e_ent);
         end
         checks++;
         if (rs_full !== model_full()) begin
            failures++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, rs_full, model_full());
         end
      end
      idle(); rdy = 1'b1;
   endtask

   initial begin
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_issue_bypass();
      test_fill_full();
      test_clear();
      test_rdy_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
